// File: rtl/osyrys64_pkg.sv
// osyrys64_pkg: shared definitions for the osyrys64 integer ALU decode path.
//   - RV64I major opcode constants for the ALU-class instructions
//   - ALU_* operation encodings (8-bit) and MD_* M-extension encodings
//     (8-bit, numerically disjoint from ALU_*)
//   - operand select enums and the decode_t payload struct
// Payload fields for immediate and PC are XLEN_MAX wide; narrower datapaths
// take the low bits.
package osyrys64_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [7:0] ALU_ADD  = 8'h00;
  localparam logic [7:0] ALU_SUB  = 8'h01;
  localparam logic [7:0] ALU_SLL  = 8'h02;
  localparam logic [7:0] ALU_SLT  = 8'h03;
  localparam logic [7:0] ALU_SLTU = 8'h04;
  localparam logic [7:0] ALU_XOR  = 8'h05;
  localparam logic [7:0] ALU_SRL  = 8'h06;
  localparam logic [7:0] ALU_SRA  = 8'h07;
  localparam logic [7:0] ALU_OR   = 8'h08;
  localparam logic [7:0] ALU_AND  = 8'h09;
  localparam logic [7:0] ALU_ADDW = 8'h0A;
  localparam logic [7:0] ALU_SUBW = 8'h0B;
  localparam logic [7:0] ALU_SLLW = 8'h0C;
  localparam logic [7:0] ALU_SRLW = 8'h0D;
  localparam logic [7:0] ALU_SRAW = 8'h0E;

  localparam logic [7:0] MD_MUL    = 8'h20;
  localparam logic [7:0] MD_MULH   = 8'h21;
  localparam logic [7:0] MD_MULHSU = 8'h22;
  localparam logic [7:0] MD_MULHU  = 8'h23;
  localparam logic [7:0] MD_DIV    = 8'h24;
  localparam logic [7:0] MD_DIVU   = 8'h25;
  localparam logic [7:0] MD_REM    = 8'h26;
  localparam logic [7:0] MD_REMU   = 8'h27;
  localparam logic [7:0] MD_MULW   = 8'h28;
  localparam logic [7:0] MD_DIVW   = 8'h29;
  localparam logic [7:0] MD_DIVUW  = 8'h2A;
  localparam logic [7:0] MD_REMW   = 8'h2B;
  localparam logic [7:0] MD_REMUW  = 8'h2C;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_sel_e;

  typedef enum logic {
    SRC2_RS2 = 1'b0,
    SRC2_IMM = 1'b1
  } src2_sel_e;

  typedef struct packed {
    logic [7:0]          alu_control;
    src1_sel_e           src1_sel;
    src2_sel_e           src2_sel;
    logic [XLEN_MAX-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rd_we;
    logic [XLEN_MAX-1:0] pc;
    logic                illegal;
    logic                muldiv;
  } decode_t;

  // funct3 -> 64-bit M-extension op (MUL..REMU share funct3 order)
  function automatic logic [7:0] md_op(input logic [2:0] funct3);
    logic [7:0] op;
    case (funct3)
      3'b000:  op = MD_MUL;
      3'b001:  op = MD_MULH;
      3'b010:  op = MD_MULHSU;
      3'b011:  op = MD_MULHU;
      3'b100:  op = MD_DIV;
      3'b101:  op = MD_DIVU;
      3'b110:  op = MD_REM;
      default: op = MD_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb: purely combinational decode of one RV64I ALU-class
// instruction into a decode_t payload.
// Parameters:
//   XLEN        datapath width of pc (<= XLEN_MAX)
//   EN_WORD_OPS when 0, OP-32 / OP-IMM-32 decode as illegal
// Optional feature macro: OSYRYS64_MULDIV_DECODE_EN makes funct7=0000001
// in OP / OP-32 legal M-extension ops; otherwise those encodings are illegal.
// Ports:
//   instr  in  32    instruction word
//   pc     in  XLEN  instruction PC (carried into the payload)
//   dec    out       decoded payload
module alu_decode_comb
  import osyrys64_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit EN_WORD_OPS = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decode_t         dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;

  logic [XLEN_MAX-1:0] imm_i;
  logic [XLEN_MAX-1:0] imm_u;
  logic [XLEN_MAX-1:0] shamt6;
  logic [XLEN_MAX-1:0] shamt5;
  logic [XLEN_MAX-1:0] pc_ext;
  logic                illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign funct6 = instr[31:26];

  assign imm_i  = {{52{instr[31]}}, instr[31:20]};
  assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign shamt6 = {58'b0, instr[25:20]};
  assign shamt5 = {59'b0, instr[24:20]};

  always_comb begin
    pc_ext = '0;
    pc_ext[XLEN-1:0] = pc;
  end

  always_comb begin
    dec             = '0;
    dec.alu_control = ALU_ADD;
    dec.src1_sel    = SRC1_RS1;
    dec.src2_sel    = SRC2_IMM;
    dec.rs1         = instr[19:15];
    dec.rs2         = instr[24:20];
    dec.rd          = instr[11:7];
    dec.pc          = pc_ext;
    illegal         = 1'b0;

    case (opcode)
      OPC_OP_IMM: begin
        dec.imm = imm_i;
        case (funct3)
          3'b000: dec.alu_control = ALU_ADD;
          3'b010: dec.alu_control = ALU_SLT;
          3'b011: dec.alu_control = ALU_SLTU;
          3'b100: dec.alu_control = ALU_XOR;
          3'b110: dec.alu_control = ALU_OR;
          3'b111: dec.alu_control = ALU_AND;
          3'b001: begin
            dec.imm = shamt6;
            if (funct6 == 6'b000000) dec.alu_control = ALU_SLL;
            else illegal = 1'b1;
          end
          default: begin
            dec.imm = shamt6;
            if (funct6 == 6'b000000) dec.alu_control = ALU_SRL;
            else if (funct6 == 6'b010000) dec.alu_control = ALU_SRA;
            else illegal = 1'b1;
          end
        endcase
      end

      OPC_OP: begin
        dec.src2_sel = SRC2_RS2;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec.alu_control = ALU_ADD;
            3'b001:  dec.alu_control = ALU_SLL;
            3'b010:  dec.alu_control = ALU_SLT;
            3'b011:  dec.alu_control = ALU_SLTU;
            3'b100:  dec.alu_control = ALU_XOR;
            3'b101:  dec.alu_control = ALU_SRL;
            3'b110:  dec.alu_control = ALU_OR;
            default: dec.alu_control = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec.alu_control = ALU_SUB;
            3'b101:  dec.alu_control = ALU_SRA;
            default: illegal = 1'b1;
          endcase
        end
`ifdef OSYRYS64_MULDIV_DECODE_EN
        else if (funct7 == F7_MULDIV) begin
          dec.muldiv      = 1'b1;
          dec.alu_control = md_op(funct3);
        end
`endif
        else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM_32: begin
        dec.imm = imm_i;
        if (!EN_WORD_OPS) begin
          illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000: dec.alu_control = ALU_ADDW;
            3'b001: begin
              // word shifts only have a 5-bit shamt, so instr[25] must be 0
              dec.imm = shamt5;
              if (funct7 == F7_BASE) dec.alu_control = ALU_SLLW;
              else illegal = 1'b1;
            end
            3'b101: begin
              dec.imm = shamt5;
              if (funct7 == F7_BASE) dec.alu_control = ALU_SRLW;
              else if (funct7 == F7_ALT) dec.alu_control = ALU_SRAW;
              else illegal = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
        end
      end

      OPC_OP_32: begin
        dec.src2_sel = SRC2_RS2;
        if (!EN_WORD_OPS) begin
          illegal = 1'b1;
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec.alu_control = ALU_ADDW;
            3'b001:  dec.alu_control = ALU_SLLW;
            3'b101:  dec.alu_control = ALU_SRLW;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec.alu_control = ALU_SUBW;
            3'b101:  dec.alu_control = ALU_SRAW;
            default: illegal = 1'b1;
          endcase
        end
`ifdef OSYRYS64_MULDIV_DECODE_EN
        else if (funct7 == F7_MULDIV) begin
          dec.muldiv = 1'b1;
          case (funct3)
            3'b000:  dec.alu_control = MD_MULW;
            3'b100:  dec.alu_control = MD_DIVW;
            3'b101:  dec.alu_control = MD_DIVUW;
            3'b110:  dec.alu_control = MD_REMW;
            3'b111:  dec.alu_control = MD_REMUW;
            default: illegal = 1'b1;
          endcase
        end
`endif
        else begin
          illegal = 1'b1;
        end
      end

      OPC_LUI: begin
        dec.imm      = imm_u;
        dec.src1_sel = SRC1_ZERO;
      end

      OPC_AUIPC: begin
        dec.imm      = imm_u;
        dec.src1_sel = SRC1_PC;
      end

      default: illegal = 1'b1;
    endcase

    // Illegal entries still flow downstream but must not have side effects.
    if (illegal) begin
      dec.illegal     = 1'b1;
      dec.alu_control = ALU_ADD;
      dec.rd_we       = 1'b0;
      dec.muldiv      = 1'b0;
    end else begin
      dec.rd_we = (dec.rd != 5'd0);
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decode stage in front of the osyrys64 integer ALU.
// Combinational decode (alu_decode_comb) feeds a single-entry output slot
// with valid/ready handshake, backpressure and flush.
// Parameters: XLEN (pc/imm width), EN_WORD_OPS (0 = word ops illegal).
// Optional feature macro: OSYRYS64_MULDIV_DECODE_EN (M-extension decode);
// when undefined out_muldiv is tied 0.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake
//   in_instr, in_pc            instruction word and its PC
//   flush                      kill held entry and same-cycle capture
//   out_valid/out_ready        downstream handshake
//   out_alu_control ... out_muldiv  registered decode payload
module alu_decode_stage
  import osyrys64_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit EN_WORD_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_alu_control,
  output logic [1:0]      out_src1_sel,
  output logic            out_src2_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic            out_muldiv
);

  decode_t dec_d;
  decode_t dec_q;
  logic    capture;

  alu_decode_comb #(
    .XLEN        (XLEN),
    .EN_WORD_OPS (EN_WORD_OPS)
  ) u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_d)
  );

  // The slot frees up in the same cycle it drains, giving 1 instr/cycle.
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dec_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      dec_q     <= dec_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_alu_control = dec_q.alu_control;
  assign out_src1_sel    = dec_q.src1_sel;
  assign out_src2_sel    = dec_q.src2_sel;
  assign out_imm         = dec_q.imm[XLEN-1:0];
  assign out_rs1         = dec_q.rs1;
  assign out_rs2         = dec_q.rs2;
  assign out_rd          = dec_q.rd;
  assign out_rd_we       = dec_q.rd_we;
  assign out_pc          = dec_q.pc[XLEN-1:0];
  assign out_illegal     = dec_q.illegal;
`ifdef OSYRYS64_MULDIV_DECODE_EN
  assign out_muldiv      = dec_q.muldiv;
`else
  assign out_muldiv      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;
  import osyrys64_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_alu_control;
  logic [1:0]  out_src1_sel;
  logic        out_src2_sel;
  logic [63:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we;
  logic [63:0] out_pc;
  logic        out_illegal;
  logic        out_muldiv;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  alu;
    logic [1:0]  s1;
    logic        s2;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ill, md;
    logic [63:0] pc;
    bit          full;  // compare operand selects / imm too
  } exp_t;

  exp_t exp_q[$];

  alu_decode_stage #(.XLEN(64), .EN_WORD_OPS(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_pc           (in_pc),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_alu_control (out_alu_control),
    .out_src1_sel    (out_src1_sel),
    .out_src2_sel    (out_src2_sel),
    .out_imm         (out_imm),
    .out_rs1         (out_rs1),
    .out_rs2         (out_rs2),
    .out_rd          (out_rd),
    .out_rd_we       (out_rd_we),
    .out_pc          (out_pc),
    .out_illegal     (out_illegal),
    .out_muldiv      (out_muldiv)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [7:0] alu, input logic [1:0] s1, input logic s2,
                              input logic [63:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic ill,
                              input logic md, input logic [63:0] pc, input bit full);
    exp_t e;
    e.alu = alu; e.s1 = s1; e.s2 = s2; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.we = we; e.ill = ill; e.md = md; e.pc = pc; e.full = full;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: an entry is consumed when out_valid && out_ready.
  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    #3;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry: actual pc=%h alu=%h, required no entry", out_pc, out_alu_control);
      end else begin
        e   = exp_q.pop_front();
        bad = (out_alu_control !== e.alu) || (out_rs1 !== e.rs1) || (out_rs2 !== e.rs2) ||
              (out_rd !== e.rd) || (out_rd_we !== e.we) || (out_illegal !== e.ill) ||
              (out_muldiv !== e.md) || (out_pc !== e.pc);
        if (e.full)
          bad = bad || (out_src1_sel !== e.s1) || (out_src2_sel !== e.s2) || (out_imm !== e.imm);
        if (bad) begin
          failures++;
          $display("FAIL entry_pc_%h: actual alu=%h s1=%0d s2=%0d imm=%h rs1=%0d rs2=%0d rd=%0d we=%b ill=%b md=%b pc=%h required alu=%h s1=%0d s2=%0d imm=%h rs1=%0d rs2=%0d rd=%0d we=%b ill=%b md=%b",
                   e.pc, out_alu_control, out_src1_sel, out_src2_sel, out_imm, out_rs1, out_rs2,
                   out_rd, out_rd_we, out_illegal, out_muldiv, out_pc,
                   e.alu, e.s1, e.s2, e.imm, e.rs1, e.rs2, e.rd, e.we, e.ill, e.md);
        end
      end
    end
  end

  // Called before a posedge; returns at the negedge after the capture edge
  // with in_valid still asserted.
  task automatic issue(input logic [31:0] instr, input logic [63:0] pc, input exp_t e, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: actual in_ready=0 required 1 within 20 cycles");
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  exp_t e_addi, e_sraw, e_lui, e_bad7f, e_slliw, e_mulw, e_auipc, e_sub, e_srai, e_none;

  initial begin
    e_addi  = mk(ALU_ADD, SRC1_RS1, SRC2_IMM, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 5'd31, 5'd1,
                 1'b1, 1'b0, 1'b0, 64'h1000, 1'b1);
    e_sraw  = mk(ALU_SRAW, SRC1_RS1, SRC2_RS2, 64'h0, 5'd4, 5'd5, 5'd3,
                 1'b1, 1'b0, 1'b0, 64'h1004, 1'b1);
    e_lui   = mk(ALU_ADD, SRC1_ZERO, SRC2_IMM, 64'hFFFF_FFFF_8000_0000, 5'd0, 5'd0, 5'd5,
                 1'b1, 1'b0, 1'b0, 64'h1008, 1'b1);
    e_bad7f = mk(ALU_ADD, SRC1_RS1, SRC2_IMM, 64'h0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 64'h100C, 1'b0);
    e_slliw = mk(ALU_ADD, SRC1_RS1, SRC2_IMM, 64'h0, 5'd1, 5'd0, 5'd1,
                 1'b0, 1'b1, 1'b0, 64'h1010, 1'b0);
`ifdef OSYRYS64_MULDIV_DECODE_EN
    e_mulw  = mk(MD_MULW, SRC1_RS1, SRC2_RS2, 64'h0, 5'd1, 5'd2, 5'd3,
                 1'b1, 1'b0, 1'b1, 64'h1014, 1'b1);
`else
    e_mulw  = mk(ALU_ADD, SRC1_RS1, SRC2_RS2, 64'h0, 5'd1, 5'd2, 5'd3,
                 1'b0, 1'b1, 1'b0, 64'h1014, 1'b0);
`endif
    e_auipc = mk(ALU_ADD, SRC1_PC, SRC2_IMM, 64'h0000_0000_1234_5000, 5'd8, 5'd3, 5'd0,
                 1'b0, 1'b0, 1'b0, 64'h1018, 1'b1);
    e_sub   = mk(ALU_SUB, SRC1_RS1, SRC2_RS2, 64'h0, 5'd7, 5'd8, 5'd6,
                 1'b1, 1'b0, 1'b0, 64'h2000, 1'b1);
    e_srai  = mk(ALU_SRA, SRC1_RS1, SRC2_IMM, 64'h3F, 5'd10, 5'd31, 5'd9,
                 1'b1, 1'b0, 1'b0, 64'h2004, 1'b1);
    e_none  = mk(ALU_ADD, SRC1_RS1, SRC2_IMM, 64'h0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 64'h0;
    flush = 1'b0; out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_pc", out_pc, 64'h0);
    chk("reset_out_imm", out_imm, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single ADDI, latency 1
    @(negedge clk);
    issue(32'hFFF10093, 64'h1000, e_addi, 1'b1);
    in_valid = 1'b0;
    #1 chk("addi_latency_valid", out_valid, 1'b1);

    // SRAW then LUI back-to-back
    @(negedge clk);
    issue(32'h405251BB, 64'h1004, e_sraw, 1'b1);
    #1 chk("b2b_first_valid", out_valid, 1'b1);
    issue(32'h800002B7, 64'h1008, e_lui, 1'b1);
    #1 chk("b2b_second_valid", out_valid, 1'b1);

    // illegal encodings, MULW, AUIPC with rd=x0, streamed
    issue(32'h0000007F, 64'h100C, e_bad7f, 1'b1);
    issue(32'h0200909B, 64'h1010, e_slliw, 1'b1);
    issue(32'h022081BB, 64'h1014, e_mulw, 1'b1);
    issue(32'h12345017, 64'h1018, e_auipc, 1'b1);
    in_valid = 1'b0;

    // backpressure: SUB held while SRAI waits
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h40838333, 64'h2000, e_sub, 1'b1);
    in_instr = 32'h43F55493;
    in_pc    = 64'h2004;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_alu", out_alu_control, ALU_SUB);
      chk("hold_pc", out_pc, 64'h2000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_q.push_back(e_srai);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("release_new_valid", out_valid, 1'b1);

    // flush with a held entry and a pending instruction
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h00A00113, 64'h3000, e_none, 1'b0);
    in_instr = 32'h00B00193;
    in_pc    = 64'h3004;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1 chk("flush_held_valid", out_valid, 1'b0);
    out_ready = 1'b1;

    // flush with an empty slot drops the same-cycle instruction
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h00C00213;
    in_pc    = 64'h3008;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1 chk("flush_capture_valid", out_valid, 1'b0);

    // async reset while an entry is held
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h800002B7, 64'h4000, e_none, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_pc", out_pc, 64'h0);
    chk("async_rst_imm", out_imm, 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    repeat (4) @(negedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
